// File: rtl/rst_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and loss-counter limit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package rst_sequencer_pkg;

    // Sequencer state encoding
    typedef logic [2:0] state_t;

    localparam state_t ST_WAIT_LOCK  = 3'd0;
    localparam state_t ST_HRAM_PULSE = 3'd1;
    localparam state_t ST_HRAM_WAIT  = 3'd2;
    localparam state_t ST_PERIPH_UP  = 3'd3;
    localparam state_t ST_RUN        = 3'd4;

    // Saturation value of the optional lock-loss event counter
    localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level signal.
// Latency: 2 clk cycles from the sampling edge to q.
// Backpressure: none; q follows d continuously, flops clear on resetn low.
module sync_2ff (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage shift; first stage may go metastable, second stage is clean
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Ordered reset release: HyperRAM RESET# pulse, then HyperBUS controller, then CPU, gated on PLL lock.
// Latency: cpu_resetn rises LOCK_CYCLES+HRAM_RST_CYCLES+HRAM_WAIT_CYCLES+CPU_DELAY cycles after lock_s rises (plus 2-cycle sync).
// Backpressure: none; lock loss restarts from WAIT_LOCK, sw_reset_req (PERIPH_UP/RUN only) restarts from HRAM_PULSE.
// Optional: define RST_SEQUENCER_LOSS_CNT_EN to add the 8-bit saturating lock_loss_cnt output.
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int LOCK_CYCLES      = 1024,
    parameter int HRAM_RST_CYCLES  = 4,
    parameter int HRAM_WAIT_CYCLES = 8,
    parameter int CPU_DELAY        = 16,
    parameter int CNT_W            = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       hram_rstn,
    output logic       hbus_resetn,
    output logic       cpu_resetn,
    output logic       ready
`ifdef RST_SEQUENCER_LOSS_CNT_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    // Terminal counts: each dwell ends when the counter reaches parameter-1
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(HRAM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(HRAM_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             lock_s;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    sync_2ff u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pll_locked),
        .q      (lock_s)
    );

    // Next-state and dwell-counter logic; lock loss overrides soft reset
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_ONE;
        case (state)
            ST_WAIT_LOCK: begin
                if (!lock_s) begin
                    cnt_nxt = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_nxt = ST_HRAM_PULSE;
                    cnt_nxt   = '0;
                end
            end
            ST_HRAM_PULSE: begin
                if (cnt == RST_LAST) begin
                    state_nxt = ST_HRAM_WAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_HRAM_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_nxt = ST_PERIPH_UP;
                    cnt_nxt   = '0;
                end
            end
            ST_PERIPH_UP: begin
                if (cnt == CPU_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                cnt_nxt = '0;
            end
            default: begin
                state_nxt = ST_WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase

        if ((state != ST_WAIT_LOCK) && !lock_s) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
        end else if (sw_reset_req && ((state == ST_PERIPH_UP) || (state == ST_RUN))) begin
            state_nxt = ST_HRAM_PULSE;
            cnt_nxt   = '0;
        end
    end

    // State, counter and outputs all register on the same edge, decoded from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_WAIT_LOCK;
            cnt         <= '0;
            hram_rstn   <= 1'b0;
            hbus_resetn <= 1'b0;
            cpu_resetn  <= 1'b0;
            ready       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            hram_rstn   <= (state_nxt == ST_HRAM_WAIT) || (state_nxt == ST_PERIPH_UP) ||
                           (state_nxt == ST_RUN);
            hbus_resetn <= (state_nxt == ST_PERIPH_UP) || (state_nxt == ST_RUN);
            cpu_resetn  <= (state_nxt == ST_RUN);
            ready       <= (state_nxt == ST_RUN);
        end
    end

`ifdef RST_SEQUENCER_LOSS_CNT_EN
    logic lock_loss;
    assign lock_loss = (state != ST_WAIT_LOCK) && !lock_s;

    // Saturating count of lock-loss events; only resetn clears it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_loss_cnt <= 8'h00;
        end else if (lock_loss && (lock_loss_cnt != LOSS_CNT_MAX)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer against a timeline-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rst_sequencer;

    localparam int LOCK = 8;
    localparam int R    = 4;
    localparam int W    = 8;
    localparam int D    = 16;

    logic clk          = 1'b0;
    logic resetn       = 1'b1;
    logic pll_locked   = 1'b0;
    logic sw_reset_req = 1'b0;
    logic hram_rstn;
    logic hbus_resetn;
    logic cpu_resetn;
    logic ready;
`ifdef RST_SEQUENCER_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rst_sequencer #(
        .LOCK_CYCLES      (LOCK),
        .HRAM_RST_CYCLES  (R),
        .HRAM_WAIT_CYCLES (W),
        .CPU_DELAY        (D),
        .CNT_W            (16)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pll_locked   (pll_locked),
        .sw_reset_req (sw_reset_req),
        .hram_rstn    (hram_rstn),
        .hbus_resetn  (hbus_resetn),
        .cpu_resetn   (cpu_resetn),
        .ready        (ready)
`ifdef RST_SEQUENCER_LOSS_CNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    // Reference model: a lock-qualification count, then a timeline measured from sequence start
    int n;
    bit waiting;
    int c;
    int start;
    bit d1, d2;
    int loss;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0; waiting = 1'b1; c = 0; start = 0; d1 = 1'b0; d2 = 1'b0; loss = 0;
    endtask

    task automatic model_step(input bit lk, input bit sw);
        bit ls;
        ls = d2;
        n++;
        if (!waiting) begin
            if (!ls) begin
                waiting = 1'b1;
                c = 0;
                if (loss < 255) loss++;
            end else if (sw && ((n - 1 - start) >= R + W)) begin
                start = n;
            end
        end else begin
            if (ls) begin
                c++;
                if (c == LOCK) begin
                    waiting = 1'b0;
                    start = n;
                end
            end else begin
                c = 0;
            end
        end
        d2 = d1;
        d1 = lk;
    endtask

    task automatic check_outputs();
        int e;
        bit eh, eb, ec;
        e  = n - start;
        eh = !waiting && (e >= R);
        eb = !waiting && (e >= R + W);
        ec = !waiting && (e >= R + W + D);
        check("hram_rstn", hram_rstn, eh);
        check("hbus_resetn", hbus_resetn, eb);
        check("cpu_resetn", cpu_resetn, ec);
        check("ready", ready, ec);
`ifdef RST_SEQUENCER_LOSS_CNT_EN
        check("lock_loss_cnt", lock_loss_cnt, loss);
`endif
    endtask

    // One clock cycle: drive inputs, let the edge happen, model it, compare away from the edge
    task automatic step(input bit lk, input bit sw);
        pll_locked   = lk;
        sw_reset_req = sw;
        @(posedge clk);
        model_step(lk, sw);
        @(negedge clk);
        check_outputs();
    endtask

    // Hold lock high and record the first step index at which each output is high
    task automatic run_rise(input int nsteps, input int sw_at, output int rh, output int rb, output int rc);
        rh = 0; rb = 0; rc = 0;
        for (int i = 1; i <= nsteps; i++) begin
            step(1'b1, i == sw_at);
            if (rh == 0 && hram_rstn === 1'b1)   rh = i;
            if (rb == 0 && hbus_resetn === 1'b1) rb = i;
            if (rc == 0 && cpu_resetn === 1'b1)  rc = i;
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
    task automatic do_reset();
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_hram_rstn", hram_rstn, 0);
        check("arst_hbus_resetn", hbus_resetn, 0);
        check("arst_cpu_resetn", cpu_resetn, 0);
        check("arst_ready", ready, 0);
`ifdef RST_SEQUENCER_LOSS_CNT_EN
        check("arst_lock_loss_cnt", lock_loss_cnt, 0);
`endif
        model_reset();
        pll_locked   = 1'b0;
        sw_reset_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int rh, rb, rc;
        int low_left;
        bit lk, sw;

        model_reset();
        do_reset();

        // Clean power-up with lock high from the first cycle
        run_rise(40, 0, rh, rb, rc);
        check("pwrup_hram_rise", rh, 14);
        check("pwrup_hbus_rise", rb, 22);
        check("pwrup_cpu_rise", rc, 38);

        // One-cycle lock drop in RUN: outputs drop on the third edge, then full restart
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("loss_2nd_edge_cpu", cpu_resetn, 1);
        step(1'b1, 1'b0);
        check("loss_3rd_edge_cpu", cpu_resetn, 0);
        check("loss_3rd_edge_hram", hram_rstn, 0);
        run_rise(40, 0, rh, rb, rc);
        check("loss_restart_cpu_rise", rc, 36);
`ifdef RST_SEQUENCER_LOSS_CNT_EN
        check("loss_cnt_one", lock_loss_cnt, 1);
`endif

        // Lock loss coincident with soft reset in RUN: lock loss wins
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("simul_cpu_low", cpu_resetn, 0);
        run_rise(40, 0, rh, rb, rc);
        check("simul_hram_rise", rh, 12);

        // Soft reset in RUN, plus an ignored request during HRAM_WAIT
        step(1'b1, 1'b1);
        check("sw_hram_low", hram_rstn, 0);
        check("sw_cpu_low", cpu_resetn, 0);
        run_rise(32, 6, rh, rb, rc);
        check("sw_hram_rise", rh, 4);
        check("sw_cpu_rise", rc, 28);

        // Lock chatter: 5 high, 3 low, then steady high
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        run_rise(40, 0, rh, rb, rc);
        check("chatter_cpu_rise", rc, 38);

        // Async reset during PERIPH_UP, then a full rerun
        do_reset();
        run_rise(25, 0, rh, rb, rc);
        check("periph_hbus_rise", rb, 22);
        check("periph_cpu_not_yet", rc, 0);
        do_reset();
        run_rise(40, 0, rh, rb, rc);
        check("rerun_cpu_rise", rc, 38);

        // Randomized lock drops and soft-reset requests
        low_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (low_left == 0 && $urandom_range(0, 59) == 0) low_left = $urandom_range(1, 4);
            lk = (low_left == 0);
            if (low_left > 0) low_left--;
            sw = ($urandom_range(0, 24) == 0);
            step(lk, sw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
